spi_slave: RTL and testbench

//  SPI responder (mode 0: CPOL=0, CPHA=0, MSB first, CS active-low) answering the team's SPI master.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_edge_sync.sv | 31 +++
 rtl/spi_slave.sv | 169 ++++++++++++++++
 tb/tb_spi_slave.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// +------------------------------------------------------------------+
// | spi_pkg : shared SPI definitions (mode, defaults, slave states)  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

  localparam logic CPOL      = 1'b0;
  localparam logic CPHA      = 1'b0;
  localparam logic MSB_FIRST = 1'b1;

  // Frame geometry shared with the SPI master
  localparam int F_SIZE_DEF = 8;
  localparam int F_NUM_DEF  = 4;

endpackage

`default_nettype wire

// File: rtl/spi_edge_sync.sv
// +------------------------------------------------------------------+
// | spi_edge_sync : 2-flop synchronizer + history flop, edge detect  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module spi_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], din};
    end
  end

  // Stage 2 is the synchronized level, stage 3 its one-cycle history
  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

endmodule

`default_nettype wire

// File: rtl/spi_slave.sv
// +------------------------------------------------------------------+
// | spi_slave : mode-0 SPI responder, oversampled in the clk domain  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module spi_slave
  import spi_pkg::*;
#(
  parameter int F_SIZE  = F_SIZE_DEF,
  parameter int F_NUM   = F_NUM_DEF,
  parameter int FC_SIZE = $clog2(F_NUM) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sclk_i,
  input  logic               cs_i,
  input  logic               mosi_i,
  output logic               miso_o,
  input  logic [F_SIZE-1:0]  tx_data_i,
  output logic               tx_load_o,
  output logic [F_SIZE-1:0]  rx_data_o,
  output logic               rx_valid_o,
  output logic [FC_SIZE-1:0] f_cnt_o,
  output logic               busy_o,
  output logic               frame_err_o
);

  localparam int BC_W = (F_SIZE > 2) ? $clog2(F_SIZE) : 1;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [1:0] mosi_q;
  logic mosi_s;

  spi_edge_sync u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sclk_i),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_edge_sync u_sync_cs (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (cs_i),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // MOSI gets the same two-stage delay so it lines up with the sclk edge flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mosi_q <= 2'b00;
    end else begin
      mosi_q <= {mosi_q[0], mosi_i};
    end
  end
  assign mosi_s = mosi_q[1];

  spi_state_t        state, state_nxt;
  logic [BC_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [FC_SIZE-1:0] f_cnt, f_cnt_nxt;
  logic [F_SIZE-1:0] shift_tx, shift_tx_nxt;
  logic [F_SIZE-1:0] shift_rx, shift_rx_nxt;
  logic [F_SIZE-1:0] rx_data, rx_data_nxt;
  logic              miso, miso_nxt;
  logic              tx_load, tx_load_nxt;
  logic              rx_valid, rx_valid_nxt;
  logic              frame_err, frame_err_nxt;
  logic              started, started_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      f_cnt     <= '0;
      shift_tx  <= '0;
      shift_rx  <= '0;
      rx_data   <= '0;
      miso      <= 1'b0;
      tx_load   <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      started   <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      f_cnt     <= f_cnt_nxt;
      shift_tx  <= shift_tx_nxt;
      shift_rx  <= shift_rx_nxt;
      rx_data   <= rx_data_nxt;
      miso      <= miso_nxt;
      tx_load   <= tx_load_nxt;
      rx_valid  <= rx_valid_nxt;
      frame_err <= frame_err_nxt;
      started   <= started_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    f_cnt_nxt     = f_cnt;
    shift_tx_nxt  = shift_tx;
    shift_rx_nxt  = shift_rx;
    rx_data_nxt   = rx_data;
    miso_nxt      = miso;
    tx_load_nxt   = 1'b0;
    rx_valid_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    started_nxt   = started;

    case (state)
      IDLE: begin
        miso_nxt = 1'b0;
        if (cs_fall) begin
          state_nxt    = ACTIVE;
          bit_cnt_nxt  = '0;
          f_cnt_nxt    = '0;
          shift_tx_nxt = tx_data_i;
          miso_nxt     = tx_data_i[F_SIZE-1];
          tx_load_nxt  = 1'b1;
          started_nxt  = 1'b0;
        end
      end
      ACTIVE: begin
        // CS release takes priority over any sclk edge seen in the same cycle
        if (cs_rise) begin
          state_nxt     = IDLE;
          miso_nxt      = 1'b0;
          frame_err_nxt = (bit_cnt != '0);
        end else if (sclk_rise) begin
          started_nxt  = 1'b1;
          shift_rx_nxt = {shift_rx[F_SIZE-2:0], mosi_s};
          if (bit_cnt == BC_W'(F_SIZE - 1)) begin
            rx_data_nxt  = {shift_rx[F_SIZE-2:0], mosi_s};
            rx_valid_nxt = 1'b1;
            bit_cnt_nxt  = '0;
            f_cnt_nxt    = (f_cnt == FC_SIZE'(F_NUM - 1)) ? '0 : f_cnt + 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end else if (sclk_fall && started) begin
          if (bit_cnt != '0) begin
            shift_tx_nxt = {shift_tx[F_SIZE-2:0], 1'b0};
            miso_nxt     = shift_tx[F_SIZE-2];
          end else begin
            shift_tx_nxt = tx_data_i;
            miso_nxt     = tx_data_i[F_SIZE-1];
            tx_load_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign miso_o      = miso;
  assign tx_load_o   = tx_load;
  assign rx_data_o   = rx_data;
  assign rx_valid_o  = rx_valid;
  assign f_cnt_o     = f_cnt;
  assign busy_o      = (state == ACTIVE);
  assign frame_err_o = frame_err;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave.sv
// +------------------------------------------------------------------+
// | tb_spi_slave : directed mode-0 master driving spi_slave          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk_i = 1'b0;
  logic       cs_i = 1'b0;
  logic       mosi_i = 1'b0;
  logic       miso_o;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_load_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic [2:0] f_cnt_o;
  logic       busy_o;
  logic       frame_err_o;

  int errors = 0;
  int checks = 0;

  spi_slave #(.F_SIZE(8), .F_NUM(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk_i      (sclk_i),
    .cs_i        (cs_i),
    .mosi_i      (mosi_i),
    .miso_o      (miso_o),
    .tx_data_i   (tx_data_i),
    .tx_load_o   (tx_load_o),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .f_cnt_o     (f_cnt_o),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled mid-cycle
  int n_rx = 0, n_load = 0, n_ferr = 0, n_overlap = 0;
  logic [7:0] rx_log [0:63];
  logic [2:0] fc_log [0:63];

  always @(negedge clk) begin
    if (rx_valid_o) begin
      rx_log[n_rx % 64] = rx_data_o;
      fc_log[n_rx % 64] = f_cnt_o;
      n_rx++;
    end
    if (tx_load_o) n_load++;
    if (frame_err_o) n_ferr++;
    if (rx_valid_o && tx_load_o) n_overlap++;
  end

  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_start();
    cs_i = 1'b1;
    repeat (8) @(negedge clk);
    cs_i = 1'b0;
    half();
  endtask

  // Shifts nbits MSB-first; on the last bit, either CS rises with the closing
  // sclk fall (last) or tx_data_i is updated to next_tx for the next frame.
  task automatic xfer_frame(input logic [7:0] mo, input int nbits, input logic [7:0] next_tx,
                            input bit last, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi_i = mo[7-i];
      half();
      sclk_i = 1'b1;
      mi[7-i] = miso_o;
      half();
      if (i == nbits - 1 && last) begin
        cs_i = 1'b1;
        sclk_i = 1'b0;
      end else begin
        if (i == nbits - 1) tx_data_i = next_tx;
        sclk_i = 1'b0;
      end
    end
    if (last) half();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cs_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({miso_o, tx_load_o, rx_valid_o, busy_o, frame_err_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000", {miso_o, tx_load_o, rx_valid_o, busy_o, frame_err_o});
    end
    checks++;
    if (rx_data_o !== 8'h00 || f_cnt_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_data: got rx=%h fc=%0d want 00/0", rx_data_o, f_cnt_o);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || n_load !== 0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b loads=%0d want 0/0", busy_o, n_load);
    end
  endtask

  task automatic test_single();
    int rx0, ld0, fe0;
    logic [7:0] mi;
    rx0 = n_rx; ld0 = n_load; fe0 = n_ferr;
    tx_data_i = 8'hA5;
    cs_start();
    xfer_frame(8'h66, 8, 8'h00, 1'b1, mi);
    repeat (4) @(negedge clk);
    checks++;
    if (n_rx - rx0 !== 1 || rx_data_o !== 8'h66) begin
      errors++;
      $display("FAIL single_rx: got n=%0d data=%h want 1/66", n_rx - rx0, rx_data_o);
    end
    checks++;
    if (mi !== 8'hA5) begin
      errors++;
      $display("FAIL single_miso: got %h want a5", mi);
    end
    checks++;
    if (f_cnt_o !== 3'd1) begin
      errors++;
      $display("FAIL single_fcnt: got %0d want 1", f_cnt_o);
    end
    checks++;
    if (n_load - ld0 !== 1 || n_ferr - fe0 !== 0) begin
      errors++;
      $display("FAIL single_pulses: got loads=%0d ferr=%0d want 1/0", n_load - ld0, n_ferr - fe0);
    end
    checks++;
    if (busy_o !== 1'b0 || miso_o !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got busy=%b miso=%b want 0/0", busy_o, miso_o);
    end
  endtask

  task automatic test_burst();
    logic [7:0] mo [0:3];
    logic [7:0] mi;
    logic [2:0] fexp [0:3];
    int rx0, ld0;
    mo[0] = 8'h66; mo[1] = 8'h70; mo[2] = 8'h67; mo[3] = 8'h61;
    fexp[0] = 3'd1; fexp[1] = 3'd2; fexp[2] = 3'd3; fexp[3] = 3'd0;
    rx0 = n_rx; ld0 = n_load;
    tx_data_i = 8'h01;
    cs_start();
    for (int k = 0; k < 4; k++) begin
      xfer_frame(mo[k], 8, 8'(k + 2), (k == 3), mi);
      checks++;
      if (mi !== 8'(k + 1)) begin
        errors++;
        $display("FAIL burst_miso%0d: got %h want %h", k, mi, 8'(k + 1));
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (n_rx - rx0 !== 4 || n_load - ld0 !== 4) begin
      errors++;
      $display("FAIL burst_counts: got rx=%0d loads=%0d want 4/4", n_rx - rx0, n_load - ld0);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rx_log[(rx0 + k) % 64] !== mo[k] || fc_log[(rx0 + k) % 64] !== fexp[k]) begin
        errors++;
        $display("FAIL burst_rx%0d: got %h fc=%0d want %h fc=%0d", k,
                 rx_log[(rx0 + k) % 64], fc_log[(rx0 + k) % 64], mo[k], fexp[k]);
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    int rx0, fe0;
    rx0 = n_rx; fe0 = n_ferr;
    tx_data_i = 8'h5A;
    cs_start();
    xfer_frame(8'hFF, 5, 8'h00, 1'b1, mi);
    repeat (4) @(negedge clk);
    checks++;
    if (n_ferr - fe0 !== 1 || n_rx - rx0 !== 0) begin
      errors++;
      $display("FAIL abort_pulses: got ferr=%0d rx=%0d want 1/0", n_ferr - fe0, n_rx - rx0);
    end
    checks++;
    if (busy_o !== 1'b0 || miso_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b miso=%b want 0/0", busy_o, miso_o);
    end
    rx0 = n_rx;
    cs_start();
    xfer_frame(8'h3C, 8, 8'h00, 1'b1, mi);
    repeat (4) @(negedge clk);
    checks++;
    if (n_rx - rx0 !== 1 || rx_data_o !== 8'h3C) begin
      errors++;
      $display("FAIL abort_next: got n=%0d data=%h want 1/3c", n_rx - rx0, rx_data_o);
    end
  endtask

  task automatic test_collision();
    logic [7:0] mi;
    int rx0, fe0;
    rx0 = n_rx; fe0 = n_ferr;
    cs_start();
    xfer_frame(8'h81, 7, 8'h00, 1'b0, mi);
    mosi_i = 1'b1;
    half();
    sclk_i = 1'b1;
    cs_i = 1'b1;
    half();
    sclk_i = 1'b0;
    half();
    checks++;
    if (n_rx - rx0 !== 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL collision: got rx=%0d busy=%b want 0/0", n_rx - rx0, busy_o);
    end
    checks++;
    if (n_ferr - fe0 !== 1) begin
      errors++;
      $display("FAIL collision_ferr: got %0d want 1", n_ferr - fe0);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] mi;
    int rx0, fe0;
    tx_data_i = 8'hFF;
    cs_start();
    xfer_frame(8'hE0, 3, 8'hFF, 1'b0, mi);
    rx0 = n_rx; fe0 = n_ferr;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || miso_o !== 1'b0 || f_cnt_o !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_idle: got busy=%b miso=%b fc=%0d want 0/0/0", busy_o, miso_o, f_cnt_o);
    end
    checks++;
    if (n_rx - rx0 !== 0 || n_ferr - fe0 !== 0) begin
      errors++;
      $display("FAIL rstmid_pulses: got rx=%0d ferr=%0d want 0/0", n_rx - rx0, n_ferr - fe0);
    end
    rx0 = n_rx;
    cs_start();
    xfer_frame(8'hC3, 8, 8'h00, 1'b1, mi);
    repeat (4) @(negedge clk);
    checks++;
    if (n_rx - rx0 !== 1 || rx_data_o !== 8'hC3) begin
      errors++;
      $display("FAIL rstmid_next: got n=%0d data=%h want 1/c3", n_rx - rx0, rx_data_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_abort();
    test_collision();
    test_reset_mid();
    checks++;
    if (n_overlap !== 0) begin
      errors++;
      $display("FAIL pulse_overlap: got %0d want 0", n_overlap);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
